// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the load/store unit in front of the data memory.
// Size and state encodings plus the default memory capacity.
package mem_access_unit_pkg;

    localparam int unsigned MEM_BYTES_DEF = 4096;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RMW  = 1'b1
    } state_e;

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Byte/half lane extraction for loads and lane merge for stores.
// Purely combinational; shared by the load path and the RMW path.
import mem_access_unit_pkg::*;

module mem_lane_align (
    input  logic [31:0] word_i,
    input  logic [1:0]  off_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [15:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);

    logic [7:0]  b;
    logic [15:0] h;

    // Pick the addressed lane, extend it, and build the merged word
    always_comb begin
        b       = word_i[{off_i, 3'b000} +: 8];
        h       = off_i[1] ? word_i[31:16] : word_i[15:0];
        load_o  = word_i;
        merge_o = word_i;
        unique case (size_i)
            SZ_BYTE: begin
                load_o = {{24{b[7] & ~unsigned_i}}, b};
                merge_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
            end
            SZ_HALF: begin
                load_o = {{16{h[15] & ~unsigned_i}}, h};
                if (off_i[1]) merge_o[31:16] = wdata_i;
                else          merge_o[15:0]  = wdata_i;
            end
            default: begin
                load_o  = word_i;
                merge_o = word_i;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit driving a word-wide data memory; sub-word stores use RMW.
// Optional macro MEM_ACCESS_ALIGN_CHECK_EN enables size/alignment faults.
import mem_access_unit_pkg::*;

module mem_access_unit #(
    parameter int unsigned MEM_BYTES = MEM_BYTES_DEF
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault,
    output logic [31:0] dm_address,
    output logic [31:0] dm_data_in,
    output logic        dm_mem_write,
    input  logic [31:0] dm_data_out
);

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [31:0] old_q, old_d;
    logic [1:0]  size_q, size_d;
    logic        valid_q, valid_d;
    logic        fault_q, fault_d;
    logic [31:0] rdata_q, rdata_d;

    logic        in_range, fault;
    logic [1:0]  eff_size;
    logic [31:0] eff_addr;
    logic        wr;
    logic [31:0] din;
    logic        rmw;
    logic [31:0] la_load, la_merge;

    assign in_range = req_addr < 32'(MEM_BYTES);
    assign rmw      = (state_q == ST_RMW);

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    // Strict mode: illegal size and misalignment both fault
    always_comb begin
        eff_size = req_size;
        eff_addr = req_addr;
        fault    = !in_range
                 || (req_size == 2'b11)
                 || (req_size == SZ_HALF && req_addr[0])
                 || (req_size == SZ_WORD && req_addr[1:0] != 2'b00);
    end
`else
    // Lenient mode: force alignment, treat size 11 as word
    always_comb begin
        eff_size = (req_size == 2'b11) ? SZ_WORD : req_size;
        eff_addr = req_addr;
        if (eff_size == SZ_HALF) eff_addr[0]   = 1'b0;
        if (eff_size == SZ_WORD) eff_addr[1:0] = 2'b00;
        fault    = !in_range;
    end
`endif

    mem_lane_align u_align (
        .word_i     (rmw ? old_q : dm_data_out),
        .off_i      (rmw ? addr_q[1:0] : eff_addr[1:0]),
        .size_i     (rmw ? size_q : eff_size),
        .unsigned_i (req_unsigned),
        .wdata_i    (wdata_q),
        .load_o     (la_load),
        .merge_o    (la_merge)
    );

    // Next-state, response and memory-port decode
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        old_d      = old_q;
        size_d     = size_q;
        valid_d    = 1'b0;
        fault_d    = 1'b0;
        rdata_d    = 32'h0;
        req_ready  = 1'b0;
        dm_address = req_addr;
        din        = 32'h0;
        wr         = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    valid_d = 1'b1;
                    if (fault) begin
                        fault_d = 1'b1;
                    end else if (!req_write) begin
                        rdata_d = la_load;
                    end else if (eff_size == SZ_WORD) begin
                        wr  = 1'b1;
                        din = req_wdata;
                    end else begin
                        valid_d = 1'b0;
                        state_d = ST_RMW;
                        addr_d  = eff_addr;
                        wdata_d = req_wdata[15:0];
                        size_d  = eff_size;
                        old_d   = dm_data_out;
                    end
                end
            end
            ST_RMW: begin
                dm_address = addr_q;
                din        = la_merge;
                wr         = 1'b1;
                valid_d    = 1'b1;
                state_d    = ST_IDLE;
            end
            default: ;
        endcase
    end

    // Reset drops the write strobe at once, even mid-RMW
    assign dm_mem_write = wr & reset_n;
    assign dm_data_in   = dm_mem_write ? din : 32'h0;

    // State, held request and registered response
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            addr_q  <= 32'h0;
            wdata_q <= 16'h0;
            old_q   <= 32'h0;
            size_q  <= 2'b00;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            old_q   <= old_d;
            size_q  <= size_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
            rdata_q <= rdata_d;
        end
    end

    assign rsp_valid = valid_q;
    assign rsp_fault = fault_q;
    assign rsp_rdata = rdata_q;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store unit sitting directly upstream of the 4 KB word-addressed data memory (dm).
- Accepts one load/store request per handshake from the execute stage and drives the dm address, write-data and write-enable ports.
- Performs byte/half-word stores as a two-cycle read-modify-write, because dm only writes whole words.
- Extracts and sign/zero-extends load data, returns a registered response to write-back, and flags misaligned or out-of-range accesses.

Parameters:
- MEM_BYTES, 4096: dm capacity in bytes; addresses >= MEM_BYTES are out of range.

Ports:
- clock  in  1  rising-edge clock shared with dm
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request this cycle
- req_write  in  1  1=store, 0=load
- req_size  in  2  00=byte, 01=half, 10=word, 11=illegal
- req_unsigned  in  1  loads only: 1=zero-extend, 0=sign-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  32  extended load data; 0 for stores and faults
- rsp_fault  out  1  misaligned, illegal size or out of range; qualified by rsp_valid
- dm_address  out  32  to dm address
- dm_data_in  out  32  to dm data_in
- dm_mem_write  out  1  to dm mem_write
- dm_data_out  in  32  from dm data_out (combinational read)

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_fault=0.
  - Held address/data registers cleared; dm_mem_write=0 immediately.
- States: IDLE, RMW.
- req_ready=1 only in IDLE. Accept = req_valid & req_ready.
- Fault check on the request:
  - size 11 is a fault.
  - half with addr[0]=1 is a fault.
  - word with addr[1:0]!=0 is a fault.
  - addr >= MEM_BYTES is a fault.
- Faulting request:
  - No dm write is issued.
  - Next cycle: rsp_valid=1, rsp_fault=1, rsp_rdata=0. State stays IDLE.
- Load, IDLE:
  - dm_address=req_addr, dm_mem_write=0.
  - Select the lane by addr[1:0], little-endian: byte lane k = bits [8k+7:8k]; half lane = addr[1].
  - Extend per req_unsigned and register.
  - Next cycle: rsp_valid=1, rsp_fault=0. Latency 1, back-to-back loads at full rate.
- Word store, IDLE:
  - dm_address=req_addr, dm_data_in=req_wdata, dm_mem_write=1 in the accept cycle.
  - rsp_valid pulses next cycle. Latency 1.
- Byte/half store:
  - Accept cycle: read dm_data_out at req_addr; latch old word, addr, wdata and size; go to RMW; dm_mem_write=0.
  - RMW cycle: dm_address=held addr; dm_data_in=old word with the addressed lane replaced by wdata[7:0] or wdata[15:0]; dm_mem_write=1; return to IDLE.
  - rsp_valid pulses the cycle after RMW. Latency 2; req_ready=0 during RMW.
- dm_address defaults:
  - In IDLE with no accept: dm_address=req_addr.
  - In RMW: dm_address=held addr.
  - dm_data_in is 0 whenever dm_mem_write=0.
- No response back-pressure: rsp_valid is a single-cycle pulse and the consumer must take it.
- Reset asserted during RMW: the write is suppressed (dm_mem_write drops asynchronously) and no response is generated.
- A load accepted in the cycle after an RMW write sees the updated word, because dm writes on the clock edge and reads combinationally.

Optional Feature:
- Macro: MEM_ACCESS_ALIGN_CHECK_EN.
- Defined: fault behaviour exactly as above.
- Undefined:
  - No misalignment or size checks. Address bits below the access size are forced to 0 (half: bit0; word: bits[1:0]). Size 11 is treated as word.
  - The out-of-range check remains; rsp_fault reflects range only.

Decomposition:
- Shared package holds:
  - size encodings: SZ_BYTE, SZ_HALF, SZ_WORD.
  - state encodings: ST_IDLE, ST_RMW.
  - MEM_BYTES default.
- One natural sub-module: mem_lane_align, purely combinational. It performs load lane extraction/extension and store lane merge, and is shared by the load path and the RMW path.

Test Plan:
- Preload dm word 0x100 = 0x8899AABB; load byte signed @0x101 -> rsp_rdata=0xFFFFFFAA one cycle later; unsigned -> 0x000000AA.
- Word 0x100 = 0x8899AABB; sb 0x11 @0x102 -> RMW cycle writes 0x8811AABB; req_ready low for 1 cycle; rsp_valid at cycle+2.
- sw 0xDEADBEEF @0x20, then lw @0x20 on the next cycle -> rsp_rdata=0xDEADBEEF; both have latency 1.
- lh @0x103 with the macro defined -> rsp_fault=1, rsp_rdata=0, no dm_mem_write.
- lh @0x103 with the macro undefined -> reads half at 0x102.
- sw @0x1000 (MEM_BYTES=4096) -> rsp_fault=1, dm_mem_write never asserted.
- sh 0xCAFE @0x40, reset_n pulsed low during RMW -> no write occurs (word @0x40 unchanged), rsp_valid stays 0, req_ready=1 after reset.
